lv_bist_seq: RTL and testbench



---
 rtl/lv_bist_seq.sv | 160 ++++++++++++++++
 tb/tb_lv_bist_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lv_bist_seq.sv
// LV power-on self-test sequencer: analog BIST window, verdict check, then logic BIST,
// each timeout-guarded with whole-attempt retries. Every output is registered.
module lv_bist_seq #(
    parameter int CLK_M        = 48,
    parameter int ABIST_TMO_US = 100,
    parameter int LBIST_TMO_US = 500,
    parameter int SETTLE_CYC   = 4,
    parameter int RETRY_MAX    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_bist_req,
    input  logic       i_abort,
    output logic       o_abist_en,
    input  logic       i_abist_win_dn,
    input  logic       i_abist_fail,
    output logic       o_lbist_start,
    input  logic       i_lbist_done,
    input  logic       i_lbist_fail,
    output logic       o_busy,
    output logic       o_bist_done,
    output logic       o_bist_pass,
    output logic [2:0] o_fail_code,
    output logic [1:0] o_retry_cnt
);
    localparam int A_CYC   = ABIST_TMO_US * CLK_M;
    localparam int L_CYC   = LBIST_TMO_US * CLK_M;
    localparam int MAX_CYC = (A_CYC > L_CYC) ? A_CYC : L_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam int RCW     = $clog2(RETRY_MAX + 2);

    localparam logic [TW-1:0] A_LAST = TW'(A_CYC - 1);
    localparam logic [TW-1:0] L_LAST = TW'(L_CYC - 1);
    localparam logic [TW-1:0] S_LAST = TW'(SETTLE_CYC - 1);

    localparam logic [2:0] FC_NONE = 3'd0;
    localparam logic [2:0] FC_AFAIL = 3'd1;
    localparam logic [2:0] FC_ATMO = 3'd2;
    localparam logic [2:0] FC_LFAIL = 3'd3;
    localparam logic [2:0] FC_LTMO = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_ABIST, S_ACHK, S_LBIST, S_COOL, S_DONE
    } state_t;

    state_t          state, state_nx;
    logic            req_d, start, fail;
    logic [TW-1:0]   tmo_cnt;
    logic [2:0]      fcode, code_nx;
    logic [RCW-1:0]  retry_cnt, retry_nx;

    // Internal retry count is wide enough for RETRY_MAX; the reported value saturates at 3.
    function automatic logic [1:0] sat2(input logic [RCW-1:0] v);
        return (int'(v) > 3) ? 2'd3 : 2'(int'(v));
    endfunction

    always_comb begin
        start    = i_bist_req & ~req_d;
        state_nx = state;
        code_nx  = o_fail_code;
        retry_nx = retry_cnt;
        fail     = 1'b0;
        fcode    = FC_NONE;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = S_ABIST;
                    code_nx  = FC_NONE;
                    retry_nx = '0;
                end
            end
            S_ABIST: begin
                if (i_abist_win_dn) begin
                    state_nx = S_ACHK;
                end else if (tmo_cnt == A_LAST) begin
                    fail  = 1'b1;
                    fcode = FC_ATMO;
                end
            end
            S_ACHK: begin
                if (tmo_cnt == S_LAST) begin
                    if (i_abist_fail) begin
                        fail  = 1'b1;
                        fcode = FC_AFAIL;
                    end else begin
                        state_nx = S_LBIST;
                    end
                end
            end
            S_LBIST: begin
                // done is checked first so it wins over a coincident timeout
                if (i_lbist_done) begin
                    if (i_lbist_fail) begin
                        fail  = 1'b1;
                        fcode = FC_LFAIL;
                    end else begin
                        state_nx = S_DONE;
                        code_nx  = FC_NONE;
                    end
                end else if (tmo_cnt == L_LAST) begin
                    fail  = 1'b1;
                    fcode = FC_LTMO;
                end
            end
            S_COOL: begin
                if (tmo_cnt == S_LAST) state_nx = S_ABIST;
            end
            default: state_nx = S_IDLE;
        endcase

        if (fail) begin
            code_nx = fcode;
            if (int'(retry_cnt) < RETRY_MAX) begin
                retry_nx = retry_cnt + RCW'(1);
                state_nx = S_COOL;
            end else begin
                state_nx = S_DONE;
            end
        end

        if (i_abort) begin
            state_nx = S_IDLE;
            code_nx  = FC_NONE;
            retry_nx = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= S_IDLE;
            req_d         <= 1'b0;
            tmo_cnt       <= '0;
            retry_cnt     <= '0;
            o_abist_en    <= 1'b0;
            o_lbist_start <= 1'b0;
            o_busy        <= 1'b0;
            o_bist_done   <= 1'b0;
            o_bist_pass   <= 1'b0;
            o_fail_code   <= FC_NONE;
            o_retry_cnt   <= 2'd0;
        end else begin
            state     <= state_nx;
            req_d     <= i_bist_req;
            retry_cnt <= retry_nx;
            // One counter serves both timeouts and settle waits; it restarts on every state change.
            if (state_nx != state || state == S_IDLE || state == S_DONE)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);
            o_abist_en    <= (state_nx == S_ABIST) || (state_nx == S_ACHK);
            o_lbist_start <= (state_nx == S_LBIST) && (state != S_LBIST);
            o_busy        <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            o_bist_done   <= (state_nx == S_DONE);
            o_bist_pass   <= (state_nx == S_DONE) && (code_nx == FC_NONE);
            o_fail_code   <= code_nx;
            o_retry_cnt   <= sat2(retry_nx);
        end
    end

endmodule

// File: tb/tb_lv_bist_seq.sv
// Scoreboard bench for lv_bist_seq: responsive analog/logic BIST models, a per-sequence
// reference model pushing expectations, and a monitor checking each DONE presentation.
module tb_lv_bist_seq;
    localparam int CLK_M = 1, A_US = 20, L_US = 30, SETTLE = 4, RMAX = 1;
    localparam int A_T = A_US * CLK_M, L_T = L_US * CLK_M;
    localparam int NEVER = 99;

    logic       clk = 0, rst = 1;
    logic       i_bist_req = 0, i_abort = 0;
    logic       i_abist_win_dn = 0, i_abist_fail = 0, i_lbist_done = 0, i_lbist_fail = 0;
    logic       o_abist_en, o_lbist_start, o_busy, o_bist_done, o_bist_pass;
    logic [2:0] o_fail_code;
    logic [1:0] o_retry_cnt;

    lv_bist_seq #(.CLK_M(CLK_M), .ABIST_TMO_US(A_US), .LBIST_TMO_US(L_US),
                  .SETTLE_CYC(SETTLE), .RETRY_MAX(RMAX)) dut (
        .i_clk(clk), .i_rst(rst), .i_bist_req(i_bist_req), .i_abort(i_abort),
        .o_abist_en(o_abist_en), .i_abist_win_dn(i_abist_win_dn), .i_abist_fail(i_abist_fail),
        .o_lbist_start(o_lbist_start), .i_lbist_done(i_lbist_done), .i_lbist_fail(i_lbist_fail),
        .o_busy(o_busy), .o_bist_done(o_bist_done), .o_bist_pass(o_bist_pass),
        .o_fail_code(o_fail_code), .o_retry_cnt(o_retry_cnt));

    always #5 clk = ~clk;

    typedef struct {int code; int pass; int retry; int starts; int cyc; int first_code;} exp_t;
    exp_t exp_q[$];
    int checks = 0, errors = 0;

    // Per-attempt behaviour of the BIST blocks: window delay, abist verdict, done delay, lbist verdict.
    int wd[RMAX+1], dd[RMAX+1];
    bit af[RMAX+1], lf[RMAX+1];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_att(input int a, input int w, input bit f, input int d, input bit l);
        wd[a] = w; af[a] = f; dd[a] = d; lf[a] = l;
    endtask

    // Reference: walk attempts with the retry budget, summing phase lengths in cycles.
    function automatic exp_t model();
        exp_t e = '{default: 0};
        int c;
        for (int a = 0; a <= RMAX; a++) begin
            if (wd[a] == NEVER) begin
                e.cyc += A_T; c = 2;
            end else begin
                e.cyc += wd[a] + 1 + SETTLE;
                if (af[a]) c = 1;
                else begin
                    e.starts++;
                    if (dd[a] == NEVER) begin e.cyc += L_T; c = 4; end
                    else begin e.cyc += dd[a] + 1; c = lf[a] ? 3 : 0; end
                end
            end
            if (a == 0) e.first_code = c;
            e.code = c;
            if (c != 0 && e.retry < RMAX) begin e.retry++; e.cyc += SETTLE; end
            else break;
        end
        e.pass = (e.code == 0) ? 1 : 0;
        return e;
    endfunction

    // Responsive analog/logic BIST stand-ins, updated away from the active edge.
    int  att = -1, acnt = 0, ai = 0, lj = 0;
    bit  prev_en = 0, lact = 0;
    initial forever begin
        @(negedge clk);
        if (!o_busy) att = -1;
        if (o_abist_en && !prev_en) begin att++; acnt = 0; end
        else if (o_abist_en) acnt++;
        prev_en = o_abist_en;
        ai = (att < 0) ? 0 : ((att > RMAX) ? RMAX : att);
        i_abist_win_dn = o_abist_en && (acnt >= wd[ai]);
        i_abist_fail   = o_abist_en && af[ai];
        if (o_lbist_start) begin lact = 1; lj = 0; end
        else if (lact) lj++;
        if (!o_busy || o_abist_en) lact = 0;
        i_lbist_done = lact && (lj == dd[ai]);
        i_lbist_fail = lact && lf[ai];
    end

    // Monitor: sequence stats, cool-gap and held-code checks, scoreboard pop on DONE.
    int  m_starts = 0, m_cyc = 0, gap = 0;
    bit  gap_lb = 0, busy_q = 0, en_q = 0, done_q = 0;
    exp_t got;
    initial forever begin
        @(negedge clk);
        if (o_busy && !busy_q) begin m_starts = 0; m_cyc = 0; end
        if (o_busy) m_cyc++;
        if (o_lbist_start) m_starts++;
        if (o_busy && !o_abist_en) begin gap++; if (o_lbist_start) gap_lb = 1; end
        if (o_abist_en && !en_q && busy_q) begin
            if (!gap_lb) chk("cool_len", gap, SETTLE);
            if (exp_q.size() > 0) chk("retry_code_held", int'(o_fail_code), exp_q[0].first_code);
        end
        if (o_abist_en || !o_busy) begin gap = 0; gap_lb = 0; end
        if (o_bist_done && !done_q) begin
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                got = exp_q.pop_front();
                chk("fail_code", int'(o_fail_code), got.code);
                chk("pass", int'(o_bist_pass), got.pass);
                chk("retry_cnt", int'(o_retry_cnt), got.retry);
                chk("start_pulses", m_starts, got.starts);
                chk("busy_cycles", m_cyc, got.cyc);
            end
        end
        busy_q = o_busy; en_q = o_abist_en; done_q = o_bist_done;
    end

    task automatic wait_done();
        int n = 0;
        while (!o_bist_done && n < 600) begin @(negedge clk); n++; end
        if (!o_bist_done) begin
            chk("done_timeout", 0, 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_seq(input bit glitch);
        exp_q.push_back(model());
        i_bist_req = 0; @(negedge clk);
        i_bist_req = 1; @(negedge clk);
        chk("start_latency_en", int'(o_abist_en), 1);
        chk("start_done_drop", int'(o_bist_done), 0);
        if (glitch) begin
            repeat (2) @(negedge clk);
            i_bist_req = 0; @(negedge clk);
            i_bist_req = 1;
        end
        wait_done();
    endtask

    function automatic int all_out();
        return int'({o_busy, o_abist_en, o_lbist_start, o_bist_done, o_bist_pass,
                     o_fail_code, o_retry_cnt});
    endfunction

    initial begin
        int n;
        for (int a = 0; a <= RMAX; a++) set_att(a, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_out(), 0);
        rst = 0;
        @(negedge clk);
        chk("idle_outputs", all_out(), 0);

        set_att(0, 10, 0, 5, 0); set_att(1, 10, 0, 5, 0); run_seq(0);   // clean pass
        set_att(0, 10, 1, 5, 0); set_att(1, 7, 1, 5, 0);  run_seq(0);   // abist fail twice
        set_att(0, NEVER, 0, 5, 0); set_att(1, 5, 0, 3, 0); run_seq(0); // abist timeout, then pass
        set_att(0, 2, 0, NEVER, 0); set_att(1, 2, 0, NEVER, 0); run_seq(0); // lbist timeout twice
        set_att(0, 2, 0, L_T - 1, 0); run_seq(0);                       // done meets timeout
        set_att(0, 4, 0, 8, 1); set_att(1, 4, 0, 6, 0); run_seq(1);     // lbist fail, busy req edge

        // Request held high in DONE must not restart.
        repeat (10) @(negedge clk);
        chk("held_req_done", int'(o_bist_done), 1);
        chk("held_req_busy", int'(o_busy), 0);

        // Abort mid-LBIST on the retry attempt.
        set_att(0, 2, 1, 0, 0); set_att(1, 3, 0, NEVER, 0);
        i_bist_req = 0; @(negedge clk);
        i_bist_req = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(o_lbist_start && o_retry_cnt == 2'd1) && n < 200);
        chk("abort_reach_lbist", int'(o_lbist_start), 1);
        repeat (5) @(negedge clk);
        chk("pre_abort_code", int'(o_fail_code), 1);
        i_abort = 1; @(negedge clk);
        i_abort = 0;
        chk("abort_outputs", all_out(), 0);
        repeat (3) @(negedge clk);
        chk("abort_no_restart", int'(o_busy), 0);
        set_att(0, 6, 0, 4, 0); run_seq(0);

        // Asynchronous reset mid-ABIST.
        set_att(0, NEVER, 0, 0, 0);
        i_bist_req = 0; @(negedge clk);
        i_bist_req = 1;
        repeat (5) @(negedge clk);
        chk("pre_reset_en", int'(o_abist_en), 1);
        #2 rst = 1;
        #1 chk("async_reset_outputs", all_out(), 0);
        @(negedge clk); rst = 0;
        set_att(0, 1, 0, 2, 0); run_seq(0);

        // Randomized attempts.
        for (int k = 0; k < 25; k++) begin
            for (int a = 0; a <= RMAX; a++)
                set_att(a, ($urandom % 8 == 0) ? NEVER : int'($urandom_range(0, 15)),
                        ($urandom % 4 == 0),
                        ($urandom % 6 == 0) ? NEVER :
                            (($urandom % 5 == 0) ? L_T - 1 : int'($urandom_range(0, L_T - 1))),
                        ($urandom % 4 == 0));
            run_seq($urandom % 3 == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
